// File: rtl/mult_result_buf_if.sv
// Handshake bundle between the result buffer, the operand feeder (issue credits),
// the last multiplier cell (product in) and the downstream consumer (product out).
interface mult_result_buf_if #(
  parameter int W = 8
);
  logic         issue;
  logic         issue_ok;
  logic         in_vld;
  logic [W-1:0] in_prod;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_prod;

  modport master (
    output issue, in_vld, in_prod, out_rdy,
    input  issue_ok, out_vld, out_prod
  );

  modport slave (
    input  issue, in_vld, in_prod, out_rdy,
    output issue_ok, out_vld, out_prod
  );
endinterface

// File: rtl/mult_result_buf.sv
// Product FIFO with issue credits; 1-cycle in_vld->out_vld, show-ahead head, drops+sticky overflow when full.
// Backpressure via out_rdy; a pop returns its credit next cycle. MULT_RESULT_BUF_STATS_EN adds drop_cnt/max_occ.
module mult_result_buf #(
  parameter  int N     = 4,
  parameter  int M     = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_result_buf_if.slave    bus,
  output logic                full,
  output logic                empty,
  output logic                overflow
`ifdef MULT_RESULT_BUF_STATS_EN
  ,
  output logic [7:0]          drop_cnt,
  output logic [CW-1:0]       max_occ
`endif
);

  localparam int W  = M + N;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic          push;
  logic          pop;
  logic          grant;
  logic          drop;

  assign pop   = !empty && bus.out_rdy;
  assign push  = bus.in_vld && (!full || pop);
  assign drop  = bus.in_vld && full && !pop;
  assign grant = bus.issue && bus.issue_ok;

  assign bus.out_vld  = !empty;
  assign bus.out_prod = empty ? '0 : mem[rd_ptr];
  // Credits are decoded from registered state only, so a pop frees a slot one cycle later.
  assign bus.issue_ok = ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_comb begin
    inflight_next = inflight;
    if (grant && !bus.in_vld) begin
      if (inflight != CW'(DEPTH)) inflight_next = inflight + CW'(1);
    end else if (bus.in_vld && !grant) begin
      if (inflight != '0) inflight_next = inflight - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      inflight <= inflight_next;
      full     <= (count_next == CW'(DEPTH));
      empty    <= (count_next == '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef MULT_RESULT_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      max_occ  <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (count_next > max_occ)      max_occ  <= count_next;
    end
  end
`endif

endmodule
